// File: rtl/box_datapath.sv
// box_datapath: bouncing-box position register and raster scanner feeding the VGA adapter.
module box_datapath #(
    parameter int         SCREEN_W = 160,
    parameter int         SCREEN_H = 120,
    parameter int         BOX_W    = 25,
    parameter int         BOX_H    = 10,
    parameter logic [7:0] X_INIT   = 8'd0,
    parameter logic [6:0] Y_INIT   = 7'd0,
    parameter logic [2:0] COLOUR   = 3'b111
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       move_en,
    input  logic       load_coord,
    input  logic       datapath_en,
    input  logic       plot,
    input  logic [1:0] op,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot_out,
    output logic       scan_done,
    output logic       touch_edge
);
    localparam int SXW = $clog2(BOX_W);
    localparam int SYW = $clog2(BOX_H);
    localparam logic [7:0] X_MAX = 8'(SCREEN_W - BOX_W);
    localparam logic [6:0] Y_MAX = 7'(SCREEN_H - BOX_H);

    logic [7:0]     pos_x_q, pos_x_d, x_out_q, x_out_d;
    logic [6:0]     pos_y_q, pos_y_d, y_out_q, y_out_d;
    logic           dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic [SXW-1:0] scan_x_q, scan_x_d;
    logic [SYW-1:0] scan_y_q, scan_y_d;
    logic [2:0]     colour_q, colour_d;
    logic           plot_q, plot_d, done_q, done_d;
    logic           last_x, last_y, emit, scan;

    always_comb begin
        last_x   = scan_x_q == SXW'(BOX_W - 1);
        last_y   = scan_y_q == SYW'(BOX_H - 1);
        emit     = datapath_en & ~load_coord;
        scan     = datapath_en & move_en & ~load_coord;
        dir_x_d  = load_coord ? (dir_x_q ? pos_x_q != 8'd0 : pos_x_q == X_MAX) : dir_x_q;
        dir_y_d  = load_coord ? (dir_y_q ? pos_y_q != 7'd0 : pos_y_q == Y_MAX) : dir_y_q;
        pos_x_d  = load_coord ? (dir_x_d ? pos_x_q - 8'd1 : pos_x_q + 8'd1) : pos_x_q;
        pos_y_d  = load_coord ? (dir_y_d ? pos_y_q - 7'd1 : pos_y_q + 7'd1) : pos_y_q;
        scan_x_d = load_coord ? '0 : scan ? (last_x ? '0 : scan_x_q + SXW'(1)) : scan_x_q;
        scan_y_d = load_coord ? '0 : (scan & last_x) ? (last_y ? '0 : scan_y_q + SYW'(1)) : scan_y_q;
        x_out_d  = emit ? pos_x_q + 8'(scan_x_q) : x_out_q;
        y_out_d  = emit ? pos_y_q + 7'(scan_y_q) : y_out_q;
        colour_d = emit ? (op == 2'b00 ? COLOUR : 3'b000) : colour_q;
        done_d   = emit & last_x & last_y;
        plot_d   = plot & emit;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_x_q  <= X_INIT;
            pos_y_q  <= Y_INIT;
            dir_x_q  <= 1'b0;
            dir_y_q  <= 1'b0;
            scan_x_q <= '0;
            scan_y_q <= '0;
            x_out_q  <= '0;
            y_out_q  <= '0;
            colour_q <= '0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
        end else begin
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            scan_x_q <= scan_x_d;
            scan_y_q <= scan_y_d;
            x_out_q  <= x_out_d;
            y_out_q  <= y_out_d;
            colour_q <= colour_d;
            done_q   <= done_d;
            plot_q   <= plot_d;
        end
    end

    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign colour_out = colour_q;
    assign plot_out   = plot_q;
    assign scan_done  = done_q;
    assign touch_edge = pos_y_q == Y_MAX;
endmodule
